// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: round-robin sharing of the register-file write port
// among NREQ requesters, plus a 32-cycle bulk clear sequencer. All
// register-file outputs are registered; req_ready is combinational.
module regfile_wr_arbiter #(
   parameter int NREQ         = 3,
   parameter bit ZERO_PROTECT = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [NREQ*5-1:0] req_addr,
   input  logic [NREQ*32-1:0] req_data,
   output logic [NREQ-1:0]   req_ready,
   input  logic              clr_req,
   output logic              busy,
   output logic              clr_done,
   output logic              rf_we,
   output logic [4:0]        rf_waddr,
   output logic [31:0]       rf_wdata,
   output logic [15:0]       wr_count
);

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t        state_q, state_d;
   logic [1:0]    rr_ptr_q, rr_ptr_d;
   logic [4:0]    clr_cnt_q, clr_cnt_d;
   logic          rf_we_q, rf_we_d;
   logic [4:0]    rf_waddr_q, rf_waddr_d;
   logic [31:0]   rf_wdata_q, rf_wdata_d;
   logic          clr_done_q, clr_done_d;
   logic [15:0]   wr_count_q, wr_count_d;

   logic [NREQ-1:0] grant;
   logic            found;
   logic [4:0]      gnt_addr;
   logic [31:0]     gnt_data;
   logic [1:0]      gnt_nxt;
   logic            xfer;

   // Round-robin pick: first valid requester at or after rr_ptr, wrapping.
   always_comb begin
      int idx;
      int sel;
      int nxt;
      grant    = '0;
      found    = 1'b0;
      sel      = 0;
      gnt_addr = '0;
      gnt_data = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(rr_ptr_q) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!found && req_valid[idx]) begin
            found = 1'b1;
            sel   = idx;
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         if (found && sel == i) begin
            grant[i] = 1'b1;
            gnt_addr = req_addr[5*i +: 5];
            gnt_data = req_data[32*i +: 32];
         end
      end
      nxt = sel + 1;
      if (nxt >= NREQ) nxt = 0;
      gnt_nxt = 2'(nxt);
   end

   // Grants only while idle and not pre-empted by a clear command.
   assign req_ready = (state_q == IDLE && !clr_req && !rst) ? grant : '0;
   assign xfer      = |req_ready;

   // Next-state and registered-output computation.
   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      clr_cnt_d  = clr_cnt_q;
      rf_we_d    = 1'b0;
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
      clr_done_d = 1'b0;
      wr_count_d = wr_count_q;
      case (state_q)
         IDLE: begin
            if (clr_req) begin
               // First clear write (address 0) is issued on entry to CLEAR.
               state_d    = CLEAR;
               clr_cnt_d  = 5'd0;
               rf_we_d    = 1'b1;
               rf_waddr_d = 5'd0;
               rf_wdata_d = 32'd0;
            end else if (xfer) begin
               rr_ptr_d   = gnt_nxt;
               rf_waddr_d = gnt_addr;
               rf_wdata_d = gnt_data;
               rf_we_d    = !(ZERO_PROTECT && gnt_addr == 5'd0);
               if (wr_count_q != 16'hFFFF) wr_count_d = wr_count_q + 16'd1;
            end
         end
         CLEAR: begin
            // clr_cnt tracks the address currently on rf_waddr.
            if (clr_cnt_q == 5'd31) begin
               state_d    = IDLE;
               clr_done_d = 1'b1;
            end else begin
               clr_cnt_d  = clr_cnt_q + 5'd1;
               rf_we_d    = 1'b1;
               rf_waddr_d = clr_cnt_q + 5'd1;
               rf_wdata_d = 32'd0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers; reset aborts any clear in progress.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         rr_ptr_q   <= '0;
         clr_cnt_q  <= '0;
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
         clr_done_q <= 1'b0;
         wr_count_q <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         clr_cnt_q  <= clr_cnt_d;
         rf_we_q    <= rf_we_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
         clr_done_q <= clr_done_d;
         wr_count_q <= wr_count_d;
      end
   end

   assign busy     = (state_q == CLEAR);
   assign clr_done = clr_done_q;
   assign rf_we    = rf_we_q;
   assign rf_waddr = rf_waddr_q;
   assign rf_wdata = rf_wdata_q;
   assign wr_count = wr_count_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: two instances (ZERO_PROTECT 0 and 1) share
// stimulus; expected writes go through a scoreboard queue.
module tb_regfile_wr_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  req_valid;
   logic [14:0] req_addr;
   logic [95:0] req_data;
   logic        clr_req;

   logic [2:0]  ready0, ready1;
   logic        busy0, busy1, done0, done1, we0, we1;
   logic [4:0]  waddr0, waddr1;
   logic [31:0] wdata0, wdata1;
   logic [15:0] cnt0, cnt1;

   always #5 clk = ~clk;

   regfile_wr_arbiter #(.NREQ(3), .ZERO_PROTECT(1'b0)) dut0 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
      .req_data(req_data), .req_ready(ready0), .clr_req(clr_req),
      .busy(busy0), .clr_done(done0), .rf_we(we0), .rf_waddr(waddr0),
      .rf_wdata(wdata0), .wr_count(cnt0));

   regfile_wr_arbiter #(.NREQ(3), .ZERO_PROTECT(1'b1)) dut1 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
      .req_data(req_data), .req_ready(ready1), .clr_req(clr_req),
      .busy(busy1), .clr_done(done1), .rf_we(we1), .rf_waddr(waddr1),
      .rf_wdata(wdata1), .wr_count(cnt1));

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
      bit          clr;
   } wr_t;

   typedef struct {
      logic [2:0] valid;
      logic [2:0] exp_ready;
   } vec_t;

   wr_t         exp_q[$];
   vec_t        vecs[15];
   logic [4:0]  ra[3];
   logic [31:0] rd[3];
   int          checks = 0;
   int          failures = 0;
   int          exp_cnt = 0;
   logic [4:0]  last_addr = '0;
   logic [31:0] last_data = '0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // One cycle: drive, check at negedge, update the scoreboard, advance.
   task automatic step(input logic [2:0] v, input logic c, input logic [2:0] er,
                       input logic eb, input logic ed, input bit push_clr,
                       input logic [4:0] clr_a);
      wr_t w;
      int  g;
      req_valid = v;
      clr_req   = c;
      @(negedge clk);
      chk("ready0", 32'(ready0), 32'(er));
      chk("ready1", 32'(ready1), 32'(er));
      chk("busy0", 32'(busy0), 32'(eb));
      chk("busy1", 32'(busy1), 32'(eb));
      chk("done0", 32'(done0), 32'(ed));
      chk("done1", 32'(done1), 32'(ed));
      chk("count0", 32'(cnt0), exp_cnt);
      chk("count1", 32'(cnt1), exp_cnt);
      if (exp_q.size() > 0) begin
         w = exp_q.pop_front();
         last_addr = w.addr;
         last_data = w.data;
         chk("we0", 32'(we0), 32'd1);
         chk("we1", 32'(we1), 32'(w.clr || w.addr != 5'd0));
      end else begin
         chk("we0", 32'(we0), 32'd0);
         chk("we1", 32'(we1), 32'd0);
      end
      chk("waddr0", 32'(waddr0), 32'(last_addr));
      chk("waddr1", 32'(waddr1), 32'(last_addr));
      chk("wdata0", wdata0, last_data);
      chk("wdata1", wdata1, last_data);
      if (push_clr) begin
         exp_q.push_back('{addr: clr_a, data: 32'd0, clr: 1'b1});
      end else if (er != 3'b000) begin
         g = er[0] ? 0 : (er[1] ? 1 : 2);
         exp_q.push_back('{addr: ra[g], data: rd[g], clr: 1'b0});
         if (exp_cnt < 65535) exp_cnt++;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      ra[0] = 5'd5;  rd[0] = 32'hDEADBEEF;
      ra[1] = 5'd0;  rd[1] = 32'h00001234;
      ra[2] = 5'd17; rd[2] = 32'hCAFEF00D;
      for (int i = 0; i < 3; i++) begin
         req_addr[5*i +: 5]   = ra[i];
         req_data[32*i +: 32] = rd[i];
      end
      // Grant sequence from rr_ptr=0, derived by hand.
      vecs[0]  = '{3'b001, 3'b001};
      vecs[1]  = '{3'b010, 3'b010};
      vecs[2]  = '{3'b100, 3'b100};
      vecs[3]  = '{3'b111, 3'b001};
      vecs[4]  = '{3'b111, 3'b010};
      vecs[5]  = '{3'b111, 3'b100};
      vecs[6]  = '{3'b111, 3'b001};
      vecs[7]  = '{3'b111, 3'b010};
      vecs[8]  = '{3'b111, 3'b100};
      vecs[9]  = '{3'b100, 3'b100};
      vecs[10] = '{3'b011, 3'b001};
      vecs[11] = '{3'b011, 3'b010};
      vecs[12] = '{3'b000, 3'b000};
      vecs[13] = '{3'b001, 3'b001};
      vecs[14] = '{3'b000, 3'b000};

      rst = 1'b1;
      req_valid = 3'b000;
      clr_req = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_we", 32'(we0), 32'd0);
      chk("rst_waddr", 32'(waddr0), 32'd0);
      chk("rst_wdata", wdata0, 32'd0);
      chk("rst_busy", 32'(busy0), 32'd0);
      chk("rst_done", 32'(done0), 32'd0);
      chk("rst_count", 32'(cnt0), 32'd0);
      chk("rst_ready", 32'(ready0), 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      for (int i = 0; i < 15; i++)
         step(vecs[i].valid, 1'b0, vecs[i].exp_ready, 1'b0, 1'b0, 1'b0, 5'd0);

      // Bulk clear with all requesters pending; rr_ptr is 1 here.
      step(3'b111, 1'b1, 3'b000, 1'b0, 1'b0, 1'b1, 5'd0);
      for (int k = 1; k < 32; k++)
         step(3'b111, (k == 10), 3'b000, 1'b1, 1'b0, 1'b1, 5'(k));
      step(3'b111, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 5'd0);
      step(3'b111, 1'b0, 3'b010, 1'b0, 1'b1, 1'b0, 5'd0);
      step(3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 5'd0);

      // Reset in the middle of a clear.
      step(3'b000, 1'b1, 3'b000, 1'b0, 1'b0, 1'b1, 5'd0);
      for (int k = 1; k < 10; k++)
         step(3'b000, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1, 5'(k));
      req_valid = 3'b100;
      rst = 1'b1;
      #1;
      chk("arst_we0", 32'(we0), 32'd0);
      chk("arst_we1", 32'(we1), 32'd0);
      chk("arst_busy0", 32'(busy0), 32'd0);
      chk("arst_busy1", 32'(busy1), 32'd0);
      chk("arst_waddr", 32'(waddr0), 32'd0);
      chk("arst_count", 32'(cnt0), 32'd0);
      chk("arst_ready", 32'(ready0), 32'd0);
      req_valid = 3'b000;
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      exp_cnt = 0;
      last_addr = '0;
      last_data = '0;
      @(posedge clk);
      #1;
      step(3'b100, 1'b0, 3'b100, 1'b0, 1'b0, 1'b0, 5'd0);
      step(3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 5'd0);

      // Saturation of the write counter.
      req_valid = 3'b001;
      repeat (65540) @(posedge clk);
      @(negedge clk);
      chk("sat_count0", 32'(cnt0), 32'h0000FFFF);
      chk("sat_count1", 32'(cnt1), 32'h0000FFFF);
      chk("sat_we0", 32'(we0), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
